// File: rtl/alu_mdu.sv
// alu_mdu: valid/ready execute unit with single-cycle ALU ops and iterative MULU/DIVU.
// Define ALU_MDU_DIV_EN to build the restoring divider; otherwise DIVU is rejected as unknown.
module alu_mdu #(
    parameter int WIDTH = 16,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r_lo,
    output logic [WIDTH-1:0] r_hi,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CMD_W-1:0] CMD_NC   = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_SUB  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_AND  = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_OR   = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_XOR  = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_SL   = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_SR   = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_SRU  = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_MULU = CMD_W'(9);
    localparam logic [CMD_W-1:0] CMD_DIVU = CMD_W'(10);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [WIDTH-1:0] work_hi_reg;
    logic [WIDTH-1:0] work_lo_reg;
`ifdef ALU_MDU_DIV_EN
    logic             div_reg;
`endif

    logic                    shift_big;
    logic [SH_W-1:0]         sh;
    logic signed [WIDTH-1:0] sra_val;
    logic [WIDTH-1:0]        alu_lo;
    logic [WIDTH-1:0]        alu_hi;
    logic                    alu_err;
    logic                    start_iter;

    // Any bit of b at or above log2(WIDTH) means the shift clears every bit.
    assign shift_big = |(b >> SH_W);
    assign sh        = b[SH_W-1:0];
    assign sra_val   = $signed(a) >>> sh;

    always_comb begin
        alu_lo     = '0;
        alu_hi     = '0;
        alu_err    = 1'b0;
        start_iter = 1'b0;
        case (cmd)
            CMD_NC:   alu_lo = '0;
            CMD_ADD:  alu_lo = a + b;
            CMD_SUB:  alu_lo = a - b;
            CMD_AND:  alu_lo = a & b;
            CMD_OR:   alu_lo = a | b;
            CMD_XOR:  alu_lo = a ^ b;
            CMD_SL:   alu_lo = shift_big ? '0 : (a << sh);
            CMD_SR:   alu_lo = shift_big ? {WIDTH{a[WIDTH-1]}} : sra_val;
            CMD_SRU:  alu_lo = shift_big ? '0 : (a >> sh);
            CMD_MULU: start_iter = 1'b1;
            CMD_DIVU: begin
`ifdef ALU_MDU_DIV_EN
                if (b == '0) begin
                    alu_lo  = '1;
                    alu_hi  = a;
                    alu_err = 1'b1;
                end else begin
                    start_iter = 1'b1;
                end
`else
                alu_err = 1'b1;
`endif
            end
            default:  alu_err = 1'b1;
        endcase
    end

    // One iteration step: shift-add multiply, or restoring divide when enabled.
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             last_step;

    assign mul_addend = work_lo_reg[0] ? opnd_reg : '0;
    assign mul_sum    = {1'b0, work_hi_reg} + {1'b0, mul_addend};
    assign last_step  = (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef ALU_MDU_DIV_EN
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    assign div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
`endif

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        if (div_reg) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {work_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {work_lo_reg[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            opnd_reg    <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
`ifdef ALU_MDU_DIV_EN
            div_reg     <= 1'b0;
`endif
            r_lo        <= '0;
            r_hi        <= '0;
            err         <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt_reg <= '0;
                        if (start_iter) begin
                            // Multiply keeps a as addend and shifts b out; divide shifts a in.
                            state_reg   <= S_BUSY;
                            work_hi_reg <= '0;
`ifdef ALU_MDU_DIV_EN
                            div_reg     <= (cmd == CMD_DIVU);
                            opnd_reg    <= (cmd == CMD_DIVU) ? b : a;
                            work_lo_reg <= (cmd == CMD_DIVU) ? a : b;
`else
                            opnd_reg    <= a;
                            work_lo_reg <= b;
`endif
                        end else begin
                            state_reg <= S_DONE;
                            r_lo      <= alu_lo;
                            r_hi      <= alu_hi;
                            err       <= alu_err;
                        end
`ifndef CODE_FOR_SYNTHESIS
                        if (cmd > CMD_DIVU) begin
                            $display("alu_mdu: unknown cmd %0d", cmd);
                        end
`endif
                    end
                end
                S_BUSY: begin
                    work_hi_reg <= step_hi;
                    work_lo_reg <= step_lo;
                    cnt_reg     <= cnt_reg + CNT_W'(1);
                    if (last_step) begin
                        state_reg <= S_DONE;
                        r_lo      <= step_lo;
                        r_hi      <= step_hi;
                        err       <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expectations come from a reference model at issue time.
module tb_alu_mdu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r_lo;
    logic [15:0] r_hi;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_mdu #(.WIDTH(16), .CMD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_lo      (r_lo),
        .r_hi      (r_hi),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        logic [31:0] p;
        int sx;
        e.lo = 16'h0; e.hi = 16'h0; e.err = 1'b0; e.lat = 1;
        sx = int'($signed(x));
        p = 32'(x) * 32'(y);
        case (c)
            4'd0:  e.lo = 16'h0;
            4'd1:  e.lo = x + y;
            4'd2:  e.lo = x - y;
            4'd3:  e.lo = x & y;
            4'd4:  e.lo = x | y;
            4'd5:  e.lo = x ^ y;
            4'd6:  e.lo = (y > 16'd15) ? 16'h0 : 16'(x << y);
            4'd7:  e.lo = 16'(sx >>> ((y > 16'd31) ? 31 : int'(y)));
            4'd8:  e.lo = (y > 16'd15) ? 16'h0 : 16'(x >> y);
            4'd9:  begin e.lo = p[15:0]; e.hi = p[31:16]; e.lat = 17; end
            4'd10: begin
`ifdef ALU_MDU_DIV_EN
                if (y == 16'h0) begin
                    e.lo = 16'hFFFF; e.hi = x; e.err = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y; e.lat = 17;
                end
`else
                e.err = 1'b1;
`endif
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Waits (bounded) for in_ready, presents one op, returns #1 after its accept edge.
    task automatic issue(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_wait: in_ready=%b after %0d clk, want 1", in_ready, n);
        end
        cmd = c; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cmd = 4'($urandom);
        if (push) sb.push_back(model(c, x, y));
    endtask

    // Called #1 after an accept edge with out_ready high; compares the oldest expectation.
    task automatic collect(input string name);
        exp_t e;
        int lat;
        bit leak;
        lat = 1; leak = 0;
        while (!out_valid && lat < 60) begin
            if (in_ready) leak = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) leak = 1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b after %0d clk, want 1", name, out_valid, lat);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: result lo=%h with no expectation queued", name, r_lo);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d clk, want %0d clk", name, lat, e.lat);
        end
        checks++;
        if ({r_hi, r_lo, err} !== {e.hi, e.lo, e.err}) begin
            errors++;
            $display("FAIL %s_result: got lo=%h hi=%h err=%b, want lo=%h hi=%h err=%b",
                     name, r_lo, r_hi, err, e.lo, e.hi, e.err);
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL %s_in_ready: got in_ready=1 while op in flight, want 0", name);
        end
        $display("txn %s lo=%h hi=%h err=%b lat=%0d", name, r_lo, r_hi, err, lat);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: got out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        bit bad;
        checks++;
        if ({in_ready, out_valid, r_lo, r_hi, err} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b lo=%h hi=%h err=%b, want 1 0 0000 0000 0",
                     in_ready, out_valid, r_lo, r_hi, err);
        end
        issue(4'd1, 16'h1111, 16'h2222, 1'b1);
        collect("reset_pre_add");
        issue(4'd9, 16'h0007, 16'h0009, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, r_lo, r_hi, err} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got rdy=%b vld=%b lo=%h hi=%h err=%b, want 1 0 0000 0000 0",
                     in_ready, out_valid, r_lo, r_hi, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_discard: got aborted MULU retiring or in_ready low, want idle");
        end
        $display("txn reset_mid_mulu discarded");
    endtask

    task automatic test_single();
        issue(4'd1, 16'hFFFF, 16'h0002, 1'b1); collect("add_wrap");
        issue(4'd7, 16'h8000, 16'd20,   1'b1); collect("sr_big");
        issue(4'd7, 16'h8000, 16'd3,    1'b1); collect("sr_3");
        issue(4'd8, 16'h8000, 16'd15,   1'b1); collect("sru_15");
        issue(4'd8, 16'h8000, 16'd16,   1'b1); collect("sru_16");
        issue(4'd6, 16'hFFFF, 16'd16,   1'b1); collect("sl_16");
        issue(4'd6, 16'h0001, 16'd15,   1'b1); collect("sl_15");
        issue(4'd2, 16'h0003, 16'h0005, 1'b1); collect("sub_wrap");
        issue(4'd3, 16'hF0F0, 16'h3C3C, 1'b1); collect("and");
        issue(4'd4, 16'hF0F0, 16'h0F01, 1'b1); collect("or");
        issue(4'd5, 16'hAAAA, 16'hFFFF, 1'b1); collect("xor");
        issue(4'd0, 16'h1234, 16'h5678, 1'b1); collect("nc");
    endtask

    task automatic test_mulu();
        issue(4'd9, 16'hFFFF, 16'hFFFF, 1'b1); collect("mulu_max");
        issue(4'd9, 16'h1234, 16'h0000, 1'b1); collect("mulu_zero");
        issue(4'd9, 16'h00FF, 16'h0101, 1'b1); collect("mulu_mix");
    endtask

    task automatic test_divu();
        issue(4'd10, 16'd100,   16'd7,   1'b1); collect("divu_100_7");
        issue(4'd10, 16'h1234,  16'h0,   1'b1); collect("divu_by0");
        issue(4'd10, 16'hFFFF,  16'h1,   1'b1); collect("divu_by1");
        issue(4'd10, 16'd5,     16'd9,   1'b1); collect("divu_small");
    endtask

    task automatic test_unknown();
        issue(4'd13, 16'h1234, 16'h5678, 1'b1); collect("unk13");
        issue(4'd11, 16'hFFFF, 16'hFFFF, 1'b1); collect("unk11");
        issue(4'd15, 16'h0001, 16'h0000, 1'b1); collect("unk15");
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit bad;
        out_ready = 1'b0;
        issue(4'd1, 16'd3, 16'd4, 1'b1);
        // Next op is held on the inputs during the stall; it must wait for the handshake.
        cmd = 4'd5; a = 16'h00F0; b = 16'h0FF0; in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            if (out_valid !== 1'b1 || r_lo !== 16'd7 || r_hi !== 16'h0 || err !== 1'b0 || in_ready !== 1'b0)
                bad = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: got vld=%b lo=%h rdy=%b during stall, want 1 0007 0", out_valid, r_lo, in_ready);
        end
        e = sb.pop_front();
        checks++;
        if ({out_valid, r_hi, r_lo, err} !== {1'b1, e.hi, e.lo, e.err}) begin
            errors++;
            $display("FAIL bp_result: got vld=%b lo=%h hi=%h err=%b, want 1 %h %h %b",
                     out_valid, r_lo, r_hi, err, e.lo, e.hi, e.err);
        end
        $display("txn bp_add lo=%h hi=%h err=%b", r_lo, r_hi, err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_early_accept: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        sb.push_back(model(4'd5, 16'h00F0, 16'h0FF0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect("bp_next_xor");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  c;
        logic [15:0] x;
        logic [15:0] y;
        for (int i = 0; i < 14; i++) begin
            c = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            y = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            issue(c, x, y, 1'b1);
            collect($sformatf("b2b%0d_cmd%0d", i, c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cmd = 4'd0; a = 16'h0; b = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_mulu();
        test_divu();
        test_unknown();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
